// File: rtl/n64_controller_emu.sv
// n64_controller_emu: controller side of the N64 single-wire joybus.
// Samples the console line on sample_clk, decodes 8-bit commands and answers
// info (0x00) and poll (0x01) with pulse-width-encoded replies on data_tx.
// Optional feature macro: N64_RESET_CMD_EN -- when defined, command 0xFF is
// answered with the same info reply as 0x00; otherwise 0xFF gets no reply.
module n64_controller_emu #(
  parameter int CLK_PER_US   = 2,
  parameter int TURNAROUND   = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic       sample_clk,
  input  logic       rst,
  input  logic       data_rx,
  input  logic [1:0] btn,
  output logic       data_tx
);
  // Console pulses up to 1.5 us low decode as 1; replies use a 4 us bit cell.
  localparam logic [7:0]  ONE_MAX_LOW = 8'((3 * CLK_PER_US) / 2);
  localparam logic [7:0]  TX_ONE_LOW  = 8'(CLK_PER_US);
  localparam logic [7:0]  TX_ZERO_LOW = 8'(3 * CLK_PER_US);
  localparam logic [7:0]  TX_BIT_LEN  = 8'(4 * CLK_PER_US);
  localparam logic [7:0]  TX_STOP_LEN = 8'(2 * CLK_PER_US);
  localparam logic [7:0]  TURN_LEN    = 8'(TURNAROUND);
  localparam logic [7:0]  TIMEOUT_LEN = 8'(IDLE_TIMEOUT);
  localparam logic [31:0] INFO_REPLY  = 32'h0500_0200;

  typedef enum logic [2:0] {S_IDLE, S_RX, S_TURN, S_IGNORE, S_TX} state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [7:0]  cnt_q, cnt_d;          // run length of the current line level
  logic [3:0]  bit_cnt_q, bit_cnt_d;  // console bits received
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] shift_q, shift_d;      // reply, MSB is the bit on the wire
  logic [7:0]  tx_cyc_q, tx_cyc_d;    // position inside the current bit cell
  logic [5:0]  tx_left_q, tx_left_d;  // reply bits still to send, 0 = stop bit
  logic        data_tx_q, data_tx_d;
  logic        rx_fall, rx_rise;

  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign rx_rise = ~rx_prev_q & rx_sync_q;
  assign data_tx = data_tx_q;

  // Two-flop synchronizer plus one delayed copy for edge detection; idles high.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= data_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // State register and datapath flops; reset releases the line at once.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      tx_cyc_q  <= '0;
      tx_left_q <= '0;
      data_tx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      tx_cyc_q  <= tx_cyc_d;
      tx_left_q <= tx_left_d;
      data_tx_q <= data_tx_d;
    end
  end

  // Next-state logic: pulse-width decode, turnaround check, dispatch, reply shifting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    tx_cyc_d  = tx_cyc_q;
    tx_left_d = tx_left_q;
    case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d   = S_RX;
          cnt_d     = 8'd1;
          bit_cnt_d = '0;
          cmd_d     = '0;
        end
      end
      S_RX: begin
        if (rx_fall || rx_rise) begin
          cnt_d = 8'd1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (rx_rise) begin
          // On a rising edge cnt_q holds the width of the low pulse just ended.
          if (bit_cnt_q == 4'd8) begin
            state_d = S_TURN;
          end else begin
            cmd_d     = {cmd_q[6:0], (cnt_q <= ONE_MAX_LOW)};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (rx_sync_q && (cnt_d >= TIMEOUT_LEN)) begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        if (!rx_sync_q) begin
          // Console kept talking past 8 bits: this is a longer command.
          state_d = S_IGNORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d >= TURN_LEN) begin
            tx_cyc_d = '0;
            case (cmd_q)
              8'h00: begin
                state_d   = S_TX;
                shift_d   = INFO_REPLY;
                tx_left_d = 6'd24;
              end
              8'h01: begin
                state_d   = S_TX;
                shift_d   = {btn[0], btn[1], 30'b0};
                tx_left_d = 6'd32;
              end
`ifdef N64_RESET_CMD_EN
              8'hFF: begin
                state_d   = S_TX;
                shift_d   = INFO_REPLY;
                tx_left_d = 6'd24;
              end
`endif
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
      S_IGNORE: begin
        if (!rx_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (cnt_d >= TIMEOUT_LEN) begin
          state_d = S_IDLE;
        end
      end
      S_TX: begin
        if (tx_cyc_q == (((tx_left_q == 6'd0) ? TX_STOP_LEN : TX_BIT_LEN) - 8'd1)) begin
          tx_cyc_d = '0;
          if (tx_left_q == 6'd0) begin
            state_d = S_IDLE;
          end else begin
            tx_left_d = tx_left_q - 6'd1;
            shift_d   = {shift_q[30:0], 1'b0};
          end
        end else begin
          tx_cyc_d = tx_cyc_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: decode next-cycle line level so data_tx comes straight from a flop.
  always_comb begin
    data_tx_d = 1'b1;
    if (state_d == S_TX) begin
      if (tx_left_d == 6'd0) begin
        data_tx_d = 1'b0;
      end else begin
        data_tx_d = (tx_cyc_d >= (shift_d[31] ? TX_ONE_LOW : TX_ZERO_LOW));
      end
    end
  end

endmodule

// File: tb/tb_n64_controller_emu.sv
// Testbench for n64_controller_emu: drives randomized console commands on a
// wired-AND line and compares data_tx cycle by cycle against a reply model.
module tb_n64_controller_emu;
  // Sync latency (2) plus turnaround (4) from stop-bit release to first reply low.
  localparam int LEAD = 6;

  logic       clk;
  logic       rst;
  logic       con_drv;
  logic [1:0] btn;
  logic       data_tx;
  logic       data_rx;
  int         checks;
  int         passed;

  assign data_rx = con_drv & data_tx;

  n64_controller_emu dut (
    .sample_clk (clk),
    .rst        (rst),
    .data_rx    (data_rx),
    .btn        (btn),
    .data_tx    (data_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reply model: returns number of reply bits, reply left-aligned in 'reply'.
  function automatic int model_reply(input logic [7:0] cmd, input int nbits,
                                     input logic [1:0] b, output logic [31:0] reply);
    reply = '0;
    if (nbits != 8) return 0;
    if (cmd == 8'h00) begin
      reply = {8'h05, 8'h00, 8'h02, 8'h00};
      return 24;
    end
    if (cmd == 8'h01) begin
      reply = {b[0], b[1], 30'b0};
      return 32;
    end
`ifdef N64_RESET_CMD_EN
    if (cmd == 8'hFF) begin
      reply = {8'h05, 8'h00, 8'h02, 8'h00};
      return 24;
    end
`endif
    return 0;
  endfunction

  // Expected line level i samples after the console stop bit is released.
  function automatic logic exp_tx(input int nb, input logic [31:0] reply, input int i);
    int   j;
    logic b;
    j = i - LEAD;
    if (nb == 0 || j < 0) return 1'b1;
    if (j < nb * 8) begin
      b = reply[31 - (j / 8)];
      return ((j % 8) < (b ? 2 : 6)) ? 1'b0 : 1'b1;
    end
    if (j < nb * 8 + 4) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input logic v, input int n);
    con_drv = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Console sends 'nbits' bits of 'word' MSB first with randomized legal widths.
  task automatic send_cmd(input logic [31:0] word, input int nbits, input bit stop,
                          input int max_high);
    int lo;
    @(posedge clk);
    #1;
    for (int k = nbits - 1; k >= 0; k--) begin
      lo = word[k] ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 7));
      drive(1'b0, lo);
      drive(1'b1, int'($urandom_range(2, max_high)));
    end
    if (stop) drive(1'b0, int'($urandom_range(1, 3)));
    con_drv = 1'b1;
  endtask

  task automatic check_reply(input string tag, input logic [7:0] cmd, input int nbits,
                             input logic [1:0] b);
    logic [31:0] reply;
    int nb, win, mism, first_bad;
    nb = model_reply(cmd, nbits, b, reply);
    win = (nb == 0) ? 40 : LEAD + nb * 8 + 4 + 8;
    mism = 0;
    first_bad = -1;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      if (i == 10) btn = ~b;
      if (data_tx !== exp_tx(nb, reply, i)) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    $display("%-16s cmd=%02h nbits=%0d btn=%b reply_bits=%0d bad_samples=%0d first_bad=%0d",
             tag, cmd, nbits, b, nb, mism, first_bad);
    check(tag, mism, 0);
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] word, input int nbits,
                         input bit stop, input int max_high, input logic [1:0] b);
    logic [7:0] cmd;
    cmd = (nbits >= 8) ? 8'(word >> (nbits - 8)) : 8'h00;
    btn = b;
    send_cmd(word, nbits, stop, max_high);
    check_reply(tag, cmd, stop ? nbits : 0, b);
  endtask

  initial begin
    logic [7:0] ucmd;
    bit         found;
    checks  = 0;
    passed  = 0;
    rst     = 1'b1;
    con_drv = 1'b1;
    btn     = 2'b00;
    #1;
    check("reset_tx_high", {31'b0, data_tx}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reply("reset_idle", 8'h00, 0, 2'b00);

    run_cmd("info", 32'h00, 8, 1'b1, 6, 2'($urandom));
    run_cmd("poll_btn01", 32'h01, 8, 1'b1, 6, 2'b01);
    run_cmd("poll_btn11", 32'h01, 8, 1'b1, 6, 2'b11);
    for (int n = 0; n < 4; n++) run_cmd("poll_rand", 32'h01, 8, 1'b1, 6, 2'($urandom));
    run_cmd("cmd_ff", 32'hFF, 8, 1'b1, 6, 2'b11);
    for (int n = 0; n < 3; n++) begin
      ucmd = 8'($urandom_range(2, 254));
      run_cmd("unknown_cmd", {24'h0, ucmd}, 8, 1'b1, 6, 2'b11);
    end

    // Command longer than 8 bits: no reply, then a normal info command.
    run_cmd("long_cmd", {8'h0, 8'h02, 16'($urandom)}, 24, 1'b1, 3, 2'b01);
    run_cmd("info_after_long", 32'h00, 8, 1'b1, 6, 2'b10);

    // Four bits then the line idles: reception aborts, then a poll works.
    run_cmd("abort_4bits", 32'($urandom_range(0, 15)), 4, 1'b0, 6, 2'b01);
    run_cmd("poll_after_abort", 32'h01, 8, 1'b1, 6, 2'b10);

    // Reset while the poll reply is pulling the line low.
    btn = 2'b11;
    send_cmd(32'h01, 8, 1'b1, 6);
    repeat (20) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (data_tx === 1'b0) found = 1'b1;
    end
    check("rst_mid_reply_low", {31'b0, found}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_release", {31'b0, data_tx}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reply("post_rst_idle", 8'h00, 0, 2'b11);
    run_cmd("info_after_rst", 32'h00, 8, 1'b1, 6, 2'b00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/n64_controller_emu.md
# n64_controller_emu

Emulates the controller side of the Nintendo 64 single-wire joybus. The block samples the console data line with a 2 MHz clock and decodes 8-bit commands. It answers with pulse-width-encoded responses on an open-drain-style output. It sits between the console line (rx/tx split externally) and a small button source.

## Interface
- `CLK_PER_US`, 2: sample_clk cycles per µs; all timing below is scaled from this.
- `TURNAROUND`, 4: line-high cycles after the console stop bit before the reply starts.
- `IDLE_TIMEOUT`, 16: line-high cycles that abort any reception.
- `sample_clk`, in, 1: sole clock, 2 MHz, rising-edge.
- `rst`, in, 1: reset; one clock; reset is asynchronous and active-high.
- `data_rx`, in, 1: console line level; asynchronous to the block.
- `btn`, in, 2: bit0 = A button, bit1 = B button; 1 = pressed.
- `data_tx`, out, 1: 0 = pull line low, 1 = release.

## Operation
- `data_rx` passes through a 2-FF synchronizer; all decoding uses the synchronized level.
- Bit decode: a low pulse of ≤3 cycles is a 1, and ≥4 cycles is a 0. Bits are received MSB first.
- States and transitions:
  - IDLE: wait for a falling edge, then go to RX.
  - RX: decode 8 bits. After the 8th bit, the next low pulse is taken as the stop bit, then go to TURN.
  - TURN: the line must stay high for `TURNAROUND` cycles.
    - If a falling edge appears first, the command is longer than 8 bits: go to IGNORE.
    - Otherwise, dispatch on the command byte.
  - IGNORE: wait for `IDLE_TIMEOUT` consecutive high cycles, then go to IDLE.
  - TX: shift out the reply, then the stop bit, then go to IDLE.
- Abort rule: in RX, line high for `IDLE_TIMEOUT` cycles between bits sends the FSM to IDLE with no reply.
- Command 0x00 (info): reply 0x05 0x00 0x02, 24 bits (standard controller, no pak).
- Command 0x01 (poll): reply of 4 bytes, 32 bits.
  - Byte 0 = {A, B, 6'b0}.
  - Bytes 1–3 = 0x00.
- Command 0xFF (reset): covered under Configuration.
- Any other 8-bit command: no reply; return to IDLE.
- Reply bit encoding, MSB first:
  - 0 = 6 cycles low, then 2 high.
  - 1 = 2 cycles low, then 6 high.
- Controller stop bit: 4 cycles low, then release.
- `btn` is captured into the reply shift register on entry to TX. Changes during TX do not alter the reply in flight.
- `data_rx` is ignored during TX, so the block's own echo is never decoded.

## Timing
- Reset: `data_tx` = 1, FSM = IDLE, bit counters and shift register cleared.
- Reset asserted mid-TX or mid-RX: `data_tx` is released immediately (asynchronously). After release, the block waits in IDLE.
- Synchronizer latency: 2 cycles. Decode thresholds apply to synchronized pulse widths.
- First reply falling edge: exactly `TURNAROUND` cycles after the synchronized rising edge that ends the console stop bit.
- Reply length:
  - Info: 24×8 + 4 = 196 cycles low/high activity, then `data_tx` = 1.
  - Poll: 32×8 + 4 = 260 cycles.
- Back-to-back commands: a falling edge arriving in the cycle TX returns to IDLE is accepted as a new command start.

## Configuration
- `N64_RESET_CMD_EN` defined: command 0xFF is answered exactly like 0x00 (0x05 0x00 0x02).
- `N64_RESET_CMD_EN` undefined: 0xFF is treated as unknown and gets no reply.

## Test plan
- Send console 0x00 plus stop bit (1 µs low / 3 µs high per 1 bit) -> `data_tx` emits 0x05 0x00 0x02 plus a 4-cycle-low stop, starting 4 cycles after stop-bit release.
- Send 0x01 with `btn`=2'b01 -> reply 0x80 0x00 0x00 0x00; with `btn`=2'b11 -> 0xC0 0x00 0x00 0x00.
- Send 0x02 followed by 16 address bits -> no reply; FSM back in IDLE after 16 high cycles; a following 0x00 is answered correctly.
- Send 0xFF -> 3-byte info reply with `N64_RESET_CMD_EN`, and `data_tx` stays 1 without it.
- Send 4 bits, then hold the line high 20 cycles -> no reply; a subsequent 0x01 is answered.
- Assert `rst` mid-poll reply -> `data_tx` = 1 in the same cycle; after release, 0x00 is answered.
